demux_1x4_nbits_buf: RTL

- Inverse of the team's 4-to-1 N-bit selector: routes one N-bit input stream to one of four output channels, chosen by `sel`.
- Each output channel holds one registered entry with a valid/ready handshake, so a stalled consumer only blocks its own channel.
- Sits on the ALU result side, fanning the single result bus out to four destination registers/consumers.

---
 rtl/demux_1x4_nbits_buf_pkg.sv | 9 +
 rtl/demux_slot.sv | 45 ++++
 rtl/demux_1x4_nbits_buf.sv | 60 ++++++
 3 files changed

// File: rtl/demux_1x4_nbits_buf_pkg.sv
// Shared constants and types for the 1-to-4 buffered demultiplexer.
package demux_1x4_nbits_buf_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demux: a single registered entry with valid/ready handshake.
module demux_slot #(
  parameter int unsigned Bits = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            ready,
  input  logic [Bits-1:0] in_data,
  output logic            full,
  output logic [Bits-1:0] data
);

  logic            full_q, full_d;
  logic [Bits-1:0] data_q, data_d;

  // Load wins over drain so a simultaneous drain+load keeps one beat per cycle.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (full_q && ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/demux_1x4_nbits_buf.sv
// Routes one N-bit input stream to one of four independently buffered output channels.
module demux_1x4_nbits_buf
  import demux_1x4_nbits_buf_pkg::*;
#(
  parameter int unsigned Bits = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [Bits-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [Bits-1:0]  out_data_0,
  output logic [Bits-1:0]  out_data_1,
  output logic [Bits-1:0]  out_data_2,
  output logic [Bits-1:0]  out_data_3,
  output ch_mask_t         out_valid,
  input  ch_mask_t         out_ready
);

  ch_mask_t        full;
  ch_mask_t        load;
  logic [Bits-1:0] slot_data [NUM_CH];

  // Only the selected channel gates acceptance; in_valid is deliberately not a term.
  assign in_ready = !flush && (!full[sel] || out_ready[sel]);

  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .Bits (Bits)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (load[k]),
      .ready   (out_ready[k]),
      .in_data (in_data),
      .full    (full[k]),
      .data    (slot_data[k])
    );
  end

  assign out_valid  = full;
  assign out_data_0 = slot_data[0];
  assign out_data_1 = slot_data[1];
  assign out_data_2 = slot_data[2];
  assign out_data_3 = slot_data[3];

  sel_known_a: assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(sel))
    else $error("sel unknown while in_valid is high");

endmodule
